// File: rtl/cpu_pkg.sv
// Shared pipeline-control types: forwarding select codes, in-flight slot record, XZR index.
package cpu_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } pipe_slot_t;

  localparam pipe_slot_t SLOT_EMPTY = '{valid: 1'b0, rd: 5'd0, regwrite: 1'b0, memread: 1'b0};

endpackage

// File: rtl/fwd_src_cmp.sv
// Resolves one ALU source operand against the EX and MEM producers; newer producer wins.
module fwd_src_cmp
  import cpu_pkg::*;
#(
  parameter int               REG_W    = 5,
  parameter logic [REG_W-1:0] ZERO_REG = cpu_pkg::ZERO_REG
) (
  input  logic [REG_W-1:0] src,
  input  logic             use_src,
  input  pipe_slot_t       ex_slot,
  input  logic             mem_valid,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_regwrite,
  output fwd_sel_t         sel,
  output logic             ex_hit
);

  logic src_live_s;
  logic ex_wr_s;
  logic mem_wr_s;

  // Producer match and select priority for this source
  always_comb begin
    src_live_s = use_src & (src != ZERO_REG);
    ex_wr_s    = ex_slot.valid & ex_slot.regwrite & (ex_slot.rd == src);
    mem_wr_s   = mem_valid & mem_regwrite & (mem_rd == src);
    ex_hit     = src_live_s & ex_wr_s;
    sel        = FWD_RF;
    if (ex_hit) begin
      // A load in EX has no result yet; the consumer is stalled and bubbled instead.
      sel = ex_slot.memread ? FWD_RF : FWD_MEM;
    end else if (src_live_s & mem_wr_s) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard controller beside the ID/EX register.
// Optional FWD_HAZARD_STATS_EN adds saturating stall_count / fwd_count outputs.
module fwd_hazard_ctrl #(
  parameter int                   REG_W    = cpu_pkg::REG_W,
  parameter logic [REG_W-1:0]     ZERO_REG = cpu_pkg::ZERO_REG
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic [1:0]       ex_fwd_a,
  output logic [1:0]       ex_fwd_b,
  output logic             stall,
`ifdef FWD_HAZARD_STATS_EN
  output logic [31:0]      stall_count,
  output logic [31:0]      fwd_count,
`endif
  output logic             bubble
);
  import cpu_pkg::*;

  pipe_slot_t       ex_q, ex_d;
  logic             mem_valid_q, mem_valid_d;
  logic [REG_W-1:0] mem_rd_q, mem_rd_d;
  logic             mem_regwrite_q, mem_regwrite_d;
  fwd_sel_t         fwd_a_q, fwd_a_d;
  fwd_sel_t         fwd_b_q, fwd_b_d;
  fwd_sel_t         sel_a_s, sel_b_s;
  logic             hit_a_s, hit_b_s;
  logic             load_use_s;

  fwd_src_cmp #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_cmp_a (
    .src(id_rs1), .use_src(id_use_rs1), .ex_slot(ex_q),
    .mem_valid(mem_valid_q), .mem_rd(mem_rd_q), .mem_regwrite(mem_regwrite_q),
    .sel(sel_a_s), .ex_hit(hit_a_s)
  );

  fwd_src_cmp #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_cmp_b (
    .src(id_rs2), .use_src(id_use_rs2), .ex_slot(ex_q),
    .mem_valid(mem_valid_q), .mem_rd(mem_rd_q), .mem_regwrite(mem_regwrite_q),
    .sel(sel_b_s), .ex_hit(hit_b_s)
  );

  // Hazard detection; flush overrides so a killed instruction never stalls
  always_comb begin
    load_use_s = id_valid & ex_q.memread & (hit_a_s | hit_b_s);
    stall      = load_use_s & ~flush;
    bubble     = stall | flush | ~id_valid;
  end

  // Next slot contents and selects for the instruction entering EX
  always_comb begin
    // The WB slot never feeds a select decision, so only EX and MEM are held.
    mem_valid_d    = ex_q.valid;
    mem_rd_d       = ex_q.rd;
    mem_regwrite_d = ex_q.regwrite;
    ex_d           = SLOT_EMPTY;
    fwd_a_d        = FWD_RF;
    fwd_b_d        = FWD_RF;
    if (bubble) begin
      ex_d    = SLOT_EMPTY;
      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
    end else begin
      ex_d    = '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
      fwd_a_d = sel_a_s;
      fwd_b_d = sel_b_s;
    end
  end

  // Pipeline slot and select registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q           <= SLOT_EMPTY;
      mem_valid_q    <= 1'b0;
      mem_rd_q       <= '0;
      mem_regwrite_q <= 1'b0;
      fwd_a_q        <= FWD_RF;
      fwd_b_q        <= FWD_RF;
    end else begin
      ex_q           <= ex_d;
      mem_valid_q    <= mem_valid_d;
      mem_rd_q       <= mem_rd_d;
      mem_regwrite_q <= mem_regwrite_d;
      fwd_a_q        <= fwd_a_d;
      fwd_b_q        <= fwd_b_d;
    end
  end

  assign ex_fwd_a = fwd_a_q;
  assign ex_fwd_b = fwd_b_q;

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stall_count_q, stall_count_d;
  logic [31:0] fwd_count_q, fwd_count_d;

  // Saturating event counters
  always_comb begin
    stall_count_d = stall_count_q;
    fwd_count_d   = fwd_count_q;
    if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
    // Bubbles already force both selects to FWD_RF, so they never count.
    if (((fwd_a_d != FWD_RF) || (fwd_b_d != FWD_RF)) && (fwd_count_q != 32'hFFFF_FFFF)) begin
      fwd_count_d = fwd_count_q + 32'd1;
    end else begin
      fwd_count_d = fwd_count_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count_q <= 32'd0;
      fwd_count_q   <= 32'd0;
    end else begin
      stall_count_q <= stall_count_d;
      fwd_count_q   <= fwd_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign fwd_count   = fwd_count_q;
`else
  // Statistics disabled: no counters, core behaviour unchanged.
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: instruction-level pipeline model plus literal pins.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] ex_fwd_a, ex_fwd_b;
  logic       stall, bubble;
`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stall_count, fwd_count;
`endif

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .stall(stall),
`ifdef FWD_HAZARD_STATS_EN
    .stall_count(stall_count), .fwd_count(fwd_count),
`endif
    .bubble(bubble)
  );

  // Model: the two most recent instructions that entered EX (0 = in EX, 1 = in MEM).
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
  } instr_t;

  instr_t pipe_m[2];
  int     exp_a = 0;
  int     exp_b = 0;

  function automatic instr_t nop_i();
    instr_t n;
    n.v = 1'b0; n.rd = 0; n.rw = 1'b0; n.mr = 1'b0;
    return n;
  endfunction

  function automatic bit produces(instr_t p, int r);
    return p.v && p.rw && (p.rd == r) && (r != 31);
  endfunction

  function automatic int expect_sel(int src, bit used);
    if (!used || src == 31) return 0;
    if (produces(pipe_m[0], src)) return 1;
    if (produces(pipe_m[1], src)) return 2;
    return 0;
  endfunction

  function automatic bit model_stall();
    bit dep;
    dep = (id_use_rs1 && produces(pipe_m[0], int'(id_rs1))) ||
          (id_use_rs2 && produces(pipe_m[0], int'(id_rs2)));
    return id_valid && pipe_m[0].mr && dep && !flush;
  endfunction

  function automatic bit model_bubble();
    return model_stall() || flush || !id_valid;
  endfunction

  // Advance the model on each clock edge
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_m[0] <= nop_i();
      pipe_m[1] <= nop_i();
      exp_a     <= 0;
      exp_b     <= 0;
    end else begin
      pipe_m[1] <= pipe_m[0];
      if (model_bubble()) begin
        pipe_m[0] <= nop_i();
        exp_a     <= 0;
        exp_b     <= 0;
      end else begin
        pipe_m[0] <= '{1'b1, int'(id_rd), id_regwrite, id_memread};
        exp_a     <= expect_sel(int'(id_rs1), id_use_rs1);
        exp_b     <= expect_sel(int'(id_rs2), id_use_rs2);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      check("cyc_stall", int'(stall), int'(model_stall()));
      check("cyc_bubble", int'(bubble), int'(model_bubble()));
      check("cyc_fwd_a", int'(ex_fwd_a), exp_a);
      check("cyc_fwd_b", int'(ex_fwd_b), exp_b);
    end
  end

  task automatic drive(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                       input int rd, input bit rw, input bit mr, input bit fl);
    id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
    id_use_rs1 = u1; id_use_rs2 = u2; id_rd = 5'(rd);
    id_regwrite = rw; id_memread = mr; flush = fl;
    #2;
  endtask

  task automatic nop();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end

  initial begin
    #1 reset_n = 1'b0;
    nop();
    check("rst_stall", int'(stall), 0);
    check("rst_bubble", int'(bubble), 1);
    check("rst_fwd_a", int'(ex_fwd_a), 0);
    check("rst_fwd_b", int'(ex_fwd_b), 0);
`ifdef FWD_HAZARD_STATS_EN
    check("rst_stall_count", int'(stall_count), 0);
    check("rst_fwd_count", int'(fwd_count), 0);
`endif
    started = 1'b1;
    #9 reset_n = 1'b1;
    tick();

    // ADD X1,X2,X3 ; SUB X4,X1,X5
    drive(1, 2, 3, 1, 1, 1, 1, 0, 0); tick();
    drive(1, 1, 5, 1, 1, 4, 1, 0, 0);
    check("sub_stall", int'(stall), 0);
    tick();
    check("sub_fwd_a", int'(ex_fwd_a), 1);
    check("sub_fwd_b", int'(ex_fwd_b), 0);

    // ADD X1 ; ADD X8 ; ORR X6,X7,X1 -> WB path, then newer producer wins
    nop(); tick(); tick();
    drive(1, 2, 3, 1, 1, 1, 1, 0, 0); tick();
    drive(1, 2, 3, 1, 1, 8, 1, 0, 0); tick();
    drive(1, 7, 1, 1, 1, 6, 1, 0, 0); tick();
    check("orr_wb_fwd_a", int'(ex_fwd_a), 0);
    check("orr_wb_fwd_b", int'(ex_fwd_b), 2);
    drive(1, 2, 3, 1, 1, 1, 1, 0, 0); tick();
    drive(1, 2, 3, 1, 1, 1, 1, 0, 0); tick();
    drive(1, 7, 1, 1, 1, 6, 1, 0, 0); tick();
    check("orr_newer_fwd_b", int'(ex_fwd_b), 1);

    // LDUR X9 ; ADD X10,X9,X9 -> one stall, then both operands from WB
    nop(); tick(); tick();
    drive(1, 0, 0, 1, 0, 9, 1, 1, 0); tick();
    drive(1, 9, 9, 1, 1, 10, 1, 0, 0);
    check("lu_stall", int'(stall), 1);
    check("lu_bubble", int'(bubble), 1);
    tick();
    check("lu_release_stall", int'(stall), 0);
    check("lu_release_bubble", int'(bubble), 0);
    check("lu_bubble_fwd_a", int'(ex_fwd_a), 0);
    tick();
    check("lu_fwd_a", int'(ex_fwd_a), 2);
    check("lu_fwd_b", int'(ex_fwd_b), 2);

    // XZR is never a forwarding or hazard source
    nop(); tick(); tick();
    drive(1, 1, 2, 1, 1, 31, 1, 0, 0); tick();
    drive(1, 31, 31, 1, 1, 3, 1, 0, 0); tick();
    check("xzr_fwd_a", int'(ex_fwd_a), 0);
    check("xzr_fwd_b", int'(ex_fwd_b), 0);
    drive(1, 0, 0, 1, 0, 31, 1, 1, 0); tick();
    drive(1, 31, 31, 1, 1, 3, 1, 0, 0);
    check("xzr_ld_stall", int'(stall), 0);
    tick();
    check("xzr_ld_fwd_a", int'(ex_fwd_a), 0);

    // Invalid decode never stalls; flush beats load-use
    nop(); tick(); tick();
    drive(1, 0, 0, 1, 0, 9, 1, 1, 0); tick();
    drive(0, 9, 9, 1, 1, 10, 1, 0, 0);
    check("inv_stall", int'(stall), 0);
    drive(1, 9, 9, 1, 1, 10, 1, 0, 1);
    check("flush_stall", int'(stall), 0);
    check("flush_bubble", int'(bubble), 1);
    tick();
    check("flush_fwd_a", int'(ex_fwd_a), 0);
    check("flush_fwd_b", int'(ex_fwd_b), 0);
    drive(1, 9, 0, 1, 1, 11, 1, 0, 0);
    check("post_flush_stall", int'(stall), 0);
    tick();
    check("post_flush_fwd_a", int'(ex_fwd_a), 2);

    // Reset asserted mid-stall
    nop(); tick(); tick();
    drive(1, 0, 0, 1, 0, 9, 1, 1, 0); tick();
    drive(1, 9, 9, 1, 1, 10, 1, 0, 0);
    check("mid_stall", int'(stall), 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_stall", int'(stall), 0);
    check("mid_rst_fwd_a", int'(ex_fwd_a), 0);
    check("mid_rst_fwd_b", int'(ex_fwd_b), 0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    tick();
    check("post_rst_fwd_a", int'(ex_fwd_a), 0);
`ifdef FWD_HAZARD_STATS_EN
    check("post_rst_stall_count", int'(stall_count), 0);
    check("post_rst_fwd_count", int'(fwd_count), 0);
`endif
    drive(1, 2, 3, 1, 1, 1, 1, 0, 0); tick();
    drive(1, 1, 5, 1, 1, 4, 1, 0, 0); tick();
    check("post_rst_pair_fwd_a", int'(ex_fwd_a), 1);
    drive(1, 0, 0, 1, 0, 9, 1, 1, 0); tick();
    drive(1, 9, 9, 1, 1, 10, 1, 0, 0); tick();
    tick();
    check("post_rst_lu_fwd_b", int'(ex_fwd_b), 2);
`ifdef FWD_HAZARD_STATS_EN
    check("stats_stall_count", int'(stall_count), 1);
    check("stats_fwd_count", int'(fwd_count), 2);
`endif

    nop(); tick();
    started = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
